decode_stage: RTL and testbench

Decode stage of the pipelined RV32I core: drives the register-file read addresses from the IF/ID instruction, decodes control, sign-extends the immediate, bypasses same-cycle writeback data, and registers everything into the ID/EX pipeline register. It sits between the IF/ID register and the execute stage, alongside the register file, whose RD1/RD2 it consumes.

---
 rtl/riscv_pkg.sv | 77 +++++++
 rtl/decode_ctrl.sv | 89 ++++++++
 rtl/decode_stage.sv | 123 ++++++++++++
 tb/tb_decode_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation codes, immediate formats,
// result-source encoding and the control / ID-EX bundles used by the decode stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic        alusrc;
    logic        illegal;
    result_src_e resultsrc;
    alu_op_e     alucontrol;
    imm_src_e    immsrc;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memwrite;
    logic            branch;
    logic            jump;
    logic            alusrc;
    logic            valid;
    logic            illegal;
    result_src_e     resultsrc;
    alu_op_e         alucontrol;
  } idex_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational main decoder and ALU decoder: opcode/funct3/funct7[5] to the
// control bundle and immediate-format select.
module decode_ctrl
  import riscv_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output ctrl_t      ctrl_o
);

  logic    is_rtype;
  alu_op_e arith_op;

  assign is_rtype = (op_i == OP_RTYPE);

  // funct3-driven operation shared by R-type and I-ALU; SUB exists only for R-type
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3_i)
      3'b000:  arith_op = (is_rtype && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl_o = '0;
    ctrl_o.resultsrc  = RES_ALU;
    ctrl_o.alucontrol = ALU_ADD;
    ctrl_o.immsrc     = IMM_I;
    case (op_i)
      OP_LOAD: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_MEM;
      end
      OP_STORE: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.immsrc   = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alucontrol = arith_op;
      end
      OP_IALU: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.alucontrol = arith_op;
      end
      OP_BRANCH: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.alucontrol = ALU_SUB;
        ctrl_o.immsrc     = IMM_B;
      end
      OP_JAL: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.jump      = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
        ctrl_o.immsrc    = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.jump      = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
      end
      OP_LUI: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.alucontrol = ALU_PASSB;
        ctrl_o.immsrc     = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.immsrc   = IMM_U;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, control decode, immediate
// extension, writeback bypass and the ID/EX pipeline register.
module decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic            valid_d,
  input  logic            flush_e,
  input  logic            stall_e,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  input  logic            regwrite_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            regwrite_e,
  output logic            memwrite_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            alusrc_e,
  output logic            valid_e,
  output logic            illegal_e,
  output logic [1:0]      resultsrc_e,
  output logic [3:0]      alucontrol_e
);

  ctrl_t           ctrl;
  logic [XLEN-1:0] imm_ext;
  logic            fwd1;
  logic            fwd2;
  idex_t           idex_d;
  idex_t           idex_q;

  assign rs1_addr = instr_d[19:15];
  assign rs2_addr = instr_d[24:20];

  decode_ctrl u_ctrl (
    .op_i       (instr_d[6:0]),
    .funct3_i   (instr_d[14:12]),
    .funct7b5_i (instr_d[30]),
    .ctrl_o     (ctrl)
  );

  always_comb begin
    case (ctrl.immsrc)
      IMM_S:   imm_ext = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      IMM_B:   imm_ext = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      IMM_U:   imm_ext = {instr_d[31:12], 12'b0};
      default: imm_ext = {{20{instr_d[31]}}, instr_d[31:20]};
    endcase
  end

  // The register file writes on the same edge we capture, so its RD ports are stale for rd_w
  assign fwd1 = regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_addr);
  assign fwd2 = regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_addr);

  always_comb begin
    idex_d         = '0;
    idex_d.rd1     = fwd1 ? result_w : rd1_in;
    idex_d.rd2     = fwd2 ? result_w : rd2_in;
    idex_d.imm     = imm_ext;
    idex_d.pc      = pc_d;
    idex_d.pcplus4 = pcplus4_d;
    idex_d.rs1     = rs1_addr;
    idex_d.rs2     = rs2_addr;
    idex_d.rd      = instr_d[11:7];
    idex_d.valid   = valid_d;
    // A non-valid slot carries no control so it cannot write state downstream
    if (valid_d) begin
      idex_d.regwrite   = ctrl.regwrite;
      idex_d.memwrite   = ctrl.memwrite;
      idex_d.branch     = ctrl.branch;
      idex_d.jump       = ctrl.jump;
      idex_d.alusrc     = ctrl.alusrc;
      idex_d.illegal    = ctrl.illegal;
      idex_d.resultsrc  = ctrl.resultsrc;
      idex_d.alucontrol = ctrl.alucontrol;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else if (flush_e) begin
      idex_q <= '0;
    end else if (!stall_e) begin
      idex_q <= idex_d;
    end
  end

  assign rd1_e        = idex_q.rd1;
  assign rd2_e        = idex_q.rd2;
  assign imm_e        = idex_q.imm;
  assign pc_e         = idex_q.pc;
  assign pcplus4_e    = idex_q.pcplus4;
  assign rs1_e        = idex_q.rs1;
  assign rs2_e        = idex_q.rs2;
  assign rd_e         = idex_q.rd;
  assign regwrite_e   = idex_q.regwrite;
  assign memwrite_e   = idex_q.memwrite;
  assign branch_e     = idex_q.branch;
  assign jump_e       = idex_q.jump;
  assign alusrc_e     = idex_q.alusrc;
  assign valid_e      = idex_q.valid;
  assign illegal_e    = idex_q.illegal;
  assign resultsrc_e  = idex_q.resultsrc;
  assign alucontrol_e = idex_q.alucontrol;

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage with an expected-result queue, plus
// hand sequences for flush/stall and asynchronous reset.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d, flush_e, stall_e;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rd1_in, rd2_in;
  logic        regwrite_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        regwrite_e, memwrite_e, branch_e, jump_e, alusrc_e, valid_e, illegal_e;
  logic [1:0]  resultsrc_e;
  logic [3:0]  alucontrol_e;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .flush_e(flush_e), .stall_e(stall_e),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .branch_e(branch_e),
    .jump_e(jump_e), .alusrc_e(alusrc_e), .valid_e(valid_e), .illegal_e(illegal_e),
    .resultsrc_e(resultsrc_e), .alucontrol_e(alucontrol_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {regwrite, memwrite, branch, jump, alusrc, illegal}
  typedef struct {
    logic [31:0] instr, rd1, rd2;
    logic        rww;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic        valid;
    logic [31:0] e_rd1, e_rd2, e_imm;
    logic [5:0]  ctl;
    logic [1:0]  rs;
    logic [3:0]  alu;
    logic        ci, ca;
    string       tag;
  } vec_t;

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  ctl;
    logic [1:0]  rs;
    logic [3:0]  alu;
    logic        valid;
    logic        chk_data, chk_imm, chk_alu;
    string       tag;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;
  exp_t sb[$];
  vec_t vecs[$];

  function automatic vec_t mkv(input logic [31:0] instr, rd1, rd2, input logic rww,
                               input logic [4:0] rdw, input logic [31:0] resw, input logic valid,
                               input logic [31:0] e_rd1, e_rd2, e_imm, input logic [5:0] ctl,
                               input logic [1:0] rs, input logic [3:0] alu, input logic ci, ca,
                               input string tag);
    vec_t v;
    v.instr = instr; v.rd1 = rd1; v.rd2 = rd2; v.rww = rww; v.rdw = rdw; v.resw = resw;
    v.valid = valid; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_imm = e_imm; v.ctl = ctl;
    v.rs = rs; v.alu = alu; v.ci = ci; v.ca = ca; v.tag = tag;
    return v;
  endfunction

  function automatic exp_t mke(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.rd1 = v.e_rd1; e.rd2 = v.e_rd2; e.imm = v.e_imm; e.pc = pc; e.pc4 = pc + 32'd4;
    e.rs1 = v.instr[19:15]; e.rs2 = v.instr[24:20]; e.rd = v.instr[11:7];
    e.ctl = v.ctl; e.rs = v.rs; e.alu = v.alu; e.valid = v.valid;
    e.chk_data = v.valid; e.chk_imm = v.ci; e.chk_alu = v.ca; e.tag = v.tag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.tag, " regwrite_e"}, {31'd0, regwrite_e}, {31'd0, e.ctl[5]});
    chk({e.tag, " memwrite_e"}, {31'd0, memwrite_e}, {31'd0, e.ctl[4]});
    chk({e.tag, " branch_e"},   {31'd0, branch_e},   {31'd0, e.ctl[3]});
    chk({e.tag, " jump_e"},     {31'd0, jump_e},     {31'd0, e.ctl[2]});
    chk({e.tag, " alusrc_e"},   {31'd0, alusrc_e},   {31'd0, e.ctl[1]});
    chk({e.tag, " illegal_e"},  {31'd0, illegal_e},  {31'd0, e.ctl[0]});
    chk({e.tag, " valid_e"},    {31'd0, valid_e},    {31'd0, e.valid});
    chk({e.tag, " resultsrc_e"}, {30'd0, resultsrc_e}, {30'd0, e.rs});
    if (e.chk_alu) chk({e.tag, " alucontrol_e"}, {28'd0, alucontrol_e}, {28'd0, e.alu});
    if (e.chk_imm) chk({e.tag, " imm_e"}, imm_e, e.imm);
    if (e.chk_data) begin
      chk({e.tag, " rd1_e"}, rd1_e, e.rd1);
      chk({e.tag, " rd2_e"}, rd2_e, e.rd2);
      chk({e.tag, " pc_e"}, pc_e, e.pc);
      chk({e.tag, " pcplus4_e"}, pcplus4_e, e.pc4);
      chk({e.tag, " rs1_e"}, {27'd0, rs1_e}, {27'd0, e.rs1});
      chk({e.tag, " rs2_e"}, {27'd0, rs2_e}, {27'd0, e.rs2});
      chk({e.tag, " rd_e"}, {27'd0, rd_e}, {27'd0, e.rd});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " rd1_e"}, rd1_e, 32'd0);
    chk({tag, " rd2_e"}, rd2_e, 32'd0);
    chk({tag, " imm_e"}, imm_e, 32'd0);
    chk({tag, " pc_e"}, pc_e, 32'd0);
    chk({tag, " pcplus4_e"}, pcplus4_e, 32'd0);
    chk({tag, " regs_idx"}, {17'd0, rs1_e, rs2_e, rd_e}, 32'd0);
    chk({tag, " regwrite_e"}, {31'd0, regwrite_e}, 32'd0);
    chk({tag, " valid_e"}, {31'd0, valid_e}, 32'd0);
    chk({tag, " ctrl_bits"}, {27'd0, memwrite_e, branch_e, jump_e, alusrc_e, illegal_e}, 32'd0);
    chk({tag, " resultsrc_alu"}, {26'd0, resultsrc_e, alucontrol_e}, 32'd0);
    $display("[txn %0d] %s: outputs checked for zero", n_txn, tag);
    n_txn++;
  endtask

  // Drive at the falling edge, check the combinational addresses, queue the expectation
  task automatic drive(input vec_t v, input logic [31:0] pc, input logic fl, input logic st);
    @(negedge clk);
    instr_d = v.instr; rd1_in = v.rd1; rd2_in = v.rd2;
    regwrite_w = v.rww; rd_w = v.rdw; result_w = v.resw; valid_d = v.valid;
    pc_d = pc; pcplus4_d = pc + 32'd4; flush_e = fl; stall_e = st;
    #1;
    chk({v.tag, " rs1_addr"}, {27'd0, rs1_addr}, {27'd0, v.instr[19:15]});
    chk({v.tag, " rs2_addr"}, {27'd0, rs2_addr}, {27'd0, v.instr[24:20]});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: queue empty at output");
    end else begin
      e = sb.pop_front();
      compare(e);
      $display("[txn %0d] %s: instr_d=%08h compared", n_txn, e.tag, instr_d);
    end
    n_txn++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  v, add_v, lw_v, ill_v;
    exp_t  e, lw_exp;

    rst = 1'b1; instr_d = '0; pc_d = '0; pcplus4_d = '0; valid_d = 1'b0;
    flush_e = 1'b0; stall_e = 1'b0; rd1_in = '0; rd2_in = '0;
    regwrite_w = 1'b0; rd_w = '0; result_w = '0;

    #3;
    check_zero("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    add_v = mkv(32'h002081B3, 4, 5, 0, 0, 0, 1, 4, 5, 0, 6'b100000, 2'b00, 4'b0000, 0, 1, "add");
    lw_v  = mkv(32'hFFC12283, 32'h100, 7, 0, 0, 0, 1, 32'h100, 7, 32'hFFFFFFFC, 6'b100010, 2'b01, 4'b0000, 1, 1, "lw");
    ill_v = mkv(32'h0000007F, 1, 2, 0, 0, 0, 1, 1, 2, 0, 6'b000001, 2'b00, 4'b0000, 0, 0, "illegal");

    vecs.push_back(add_v);
    vecs.push_back(lw_v);
    vecs.push_back(mkv(32'hFE208CE3, 1, 2, 0, 0, 0, 1, 1, 2, 32'hFFFFFFF8, 6'b001000, 2'b00, 4'b0001, 1, 1, "beq"));
    vecs.push_back(mkv(32'h002081B3, 4, 5, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 5, 0, 6'b100000, 2'b00, 4'b0000, 0, 1, "byp_rs1"));
    vecs.push_back(mkv(32'h002081B3, 4, 5, 1, 0, 32'hDEADBEEF, 1, 4, 5, 0, 6'b100000, 2'b00, 4'b0000, 0, 1, "byp_x0"));
    vecs.push_back(mkv(32'h002081B3, 4, 5, 1, 2, 32'h12345678, 1, 4, 32'h12345678, 0, 6'b100000, 2'b00, 4'b0000, 0, 1, "byp_rs2"));
    vecs.push_back(mkv(32'h002081B3, 4, 5, 0, 1, 32'hDEADBEEF, 1, 4, 5, 0, 6'b100000, 2'b00, 4'b0000, 0, 1, "byp_nowe"));
    vecs.push_back(mkv(32'h00612423, 32'h200, 32'h99, 0, 0, 0, 1, 32'h200, 32'h99, 8, 6'b010010, 2'b00, 4'b0000, 1, 1, "sw"));
    vecs.push_back(mkv(32'h40208233, 9, 3, 0, 0, 0, 1, 9, 3, 0, 6'b100000, 2'b00, 4'b0001, 0, 1, "sub"));
    vecs.push_back(mkv(32'h4030D293, 9, 3, 0, 0, 0, 1, 9, 3, 32'h00000403, 6'b100010, 2'b00, 4'b1001, 1, 1, "srai"));
    vecs.push_back(mkv(32'h403150B3, 6, 7, 0, 0, 0, 1, 6, 7, 0, 6'b100000, 2'b00, 4'b1001, 0, 1, "sra"));
    vecs.push_back(mkv(32'h003150B3, 6, 7, 0, 0, 0, 1, 6, 7, 0, 6'b100000, 2'b00, 4'b1000, 0, 1, "srl"));
    vecs.push_back(mkv(32'hFFF00093, 0, 32'h55, 1, 0, 32'hAAAA, 1, 0, 32'h55, 32'hFFFFFFFF, 6'b100010, 2'b00, 4'b0000, 1, 1, "addi_x0"));
    vecs.push_back(mkv(32'h010000EF, 1, 2, 0, 0, 0, 1, 1, 2, 16, 6'b100100, 2'b10, 4'b0000, 1, 0, "jal"));
    vecs.push_back(mkv(32'h00008067, 1, 2, 0, 0, 0, 1, 1, 2, 0, 6'b100110, 2'b10, 4'b0000, 1, 1, "jalr"));
    vecs.push_back(mkv(32'h123452B7, 1, 2, 0, 0, 0, 1, 1, 2, 32'h12345000, 6'b100010, 2'b00, 4'b1010, 1, 1, "lui"));
    vecs.push_back(mkv(32'hFFFFF317, 1, 2, 0, 0, 0, 1, 1, 2, 32'hFFFFF000, 6'b100010, 2'b00, 4'b0000, 1, 1, "auipc"));
    vecs.push_back(mkv(32'h0020C3B3, 1, 2, 0, 0, 0, 1, 1, 2, 0, 6'b100000, 2'b00, 4'b0100, 0, 1, "xor"));
    vecs.push_back(mkv(32'h0020B433, 1, 2, 0, 0, 0, 1, 1, 2, 0, 6'b100000, 2'b00, 4'b0110, 0, 1, "sltu"));
    vecs.push_back(ill_v);
    vecs.push_back(mkv(32'h002081B3, 4, 5, 0, 0, 0, 0, 4, 5, 0, 6'b000000, 2'b00, 4'b0000, 0, 0, "bubble"));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], 32'h1000 + 32'(i) * 4, 1'b0, 1'b0);
      sb.push_back(mke(vecs[i], 32'h1000 + 32'(i) * 4));
      tick();
    end

    // flush wins over stall: a valid add becomes a bubble
    drive(add_v, 32'h2000, 1'b1, 1'b1);
    e = mke(add_v, 32'h2000);
    e.ctl = '0; e.valid = 1'b0; e.rs = 2'b00;
    e.chk_data = 1'b0; e.chk_imm = 1'b0; e.chk_alu = 1'b0; e.tag = "flush_stall";
    sb.push_back(e);
    tick();

    // load lw, then hold it for three stalled cycles while the inputs churn
    drive(lw_v, 32'h3000, 1'b0, 1'b0);
    lw_exp = mke(lw_v, 32'h3000);
    sb.push_back(lw_exp);
    tick();
    for (int k = 0; k < 3; k++) begin
      v = mkv($urandom, $urandom, $urandom, 1, 5'($urandom_range(1, 31)), $urandom, 1,
              0, 0, 0, 6'b0, 2'b0, 4'b0, 0, 0, "stall_in");
      drive(v, 32'h4000 + 32'(k) * 4, 1'b0, 1'b1);
      e = lw_exp;
      e.tag = "stall_hold";
      sb.push_back(e);
      tick();
    end

    // asynchronous reset between edges, mid-operation
    drive(add_v, 32'h5000, 1'b0, 1'b0);
    sb.push_back(mke(add_v, 32'h5000));
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    valid_d = 1'b0;

    drive(ill_v, 32'h6000, 1'b0, 1'b0);
    e = mke(ill_v, 32'h6000);
    e.tag = "illegal_after_rst";
    sb.push_back(e);
    tick();

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
